// File: rtl/cnna_axi_pkg.sv
// Shared AXI4 constants, the AWSIZE helper and the write-controller state
// encoding used by the CNNA DDR DMA engines.
package cnna_axi_pkg;

    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam int         BOUNDARY_4K = 4096;

    typedef enum logic [2:0] {
        IDLE,
        AW,
        W,
        WAIT_B,
        DONE
    } axi_wr_state_e;

    function automatic logic [2:0] awsize(input int bpb);
        int n;
        n = 0;
        while ((1 << n) < bpb) n++;
        return 3'(n);
    endfunction

endpackage

// File: rtl/obuf_wr_skid.sv
// Two-entry FIFO between the obuf RAM read port and the AXI W channel; it
// absorbs the one-cycle RAM latency so W can stream one beat per cycle.
module obuf_wr_skid #(
    parameter int DW = 128
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [DW-1:0] din,
    input  logic          pop,
    output logic [DW-1:0] dout,
    output logic [1:0]    count
);

    logic [DW-1:0] mem_q [2];
    logic [DW-1:0] mem_d [2];
    logic          wr_ptr_q, wr_ptr_d;
    logic          rd_ptr_q, rd_ptr_d;
    logic [1:0]    count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        count_d = count_q + 2'(push) - 2'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/obuf_axi_wr.sv
// Streams I_len+1 words from the obuf RAM to DDR as 4 KB-safe AXI4 INCR bursts.
// Define OBUF_AXI_WR_BRESP_CHK_EN to add the sticky O_bresp_err output.
module obuf_axi_wr
    import cnna_axi_pkg::*;
#(
    parameter int C_M_AXI_ID_WIDTH   = 1,
    parameter int C_M_AXI_USER_WIDTH = 1,
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 128,
    parameter int C_MAX_BURST        = 256,
    parameter int C_MAX_OUTSTANDING  = 4,
    parameter int C_RAM_AWIDTH       = 16
) (
    input  logic                            I_clk,
    input  logic                            I_rst_n,
    input  logic                            I_ap_start,
    output logic                            O_ap_done,
    output logic                            O_ap_idle,
    output logic                            O_ap_ready,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   I_base_addr,
    input  logic [15:0]                     I_len,
    output logic                            O_buf_rd,
    output logic [C_RAM_AWIDTH-1:0]         O_buf_raddr,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   I_buf_rdata,
    output logic [C_M_AXI_ID_WIDTH-1:0]     O_maxi_awid,
    output logic [C_M_AXI_USER_WIDTH-1:0]   O_maxi_awuser,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   O_maxi_awaddr,
    output logic [7:0]                      O_maxi_awlen,
    output logic [2:0]                      O_maxi_awsize,
    output logic [1:0]                      O_maxi_awburst,
    output logic                            O_maxi_awlock,
    output logic [3:0]                      O_maxi_awcache,
    output logic [2:0]                      O_maxi_awprot,
    output logic [3:0]                      O_maxi_awqos,
    output logic [3:0]                      O_maxi_awregion,
    output logic                            O_maxi_awvalid,
    input  logic                            I_maxi_awready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   O_maxi_wdata,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] O_maxi_wstrb,
    output logic                            O_maxi_wlast,
    output logic                            O_maxi_wvalid,
    input  logic                            I_maxi_wready,
    input  logic [C_M_AXI_ID_WIDTH-1:0]     I_maxi_bid,
    input  logic [1:0]                      I_maxi_bresp,
    input  logic                            I_maxi_bvalid,
    output logic                            O_maxi_bready
`ifdef OBUF_AXI_WR_BRESP_CHK_EN
    ,
    output logic                            O_bresp_err
`endif
);

    localparam int          BPB      = C_M_AXI_DATA_WIDTH / 8;
    localparam int          ADDR_LSB = $clog2(BPB);
    localparam int          ADDR_W   = C_M_AXI_ADDR_WIDTH;
    localparam logic [2:0]  AWSIZE_C = awsize(BPB);

    axi_wr_state_e             state_q, state_d;
    logic [ADDR_W-1:0]         addr_q, addr_d;
    logic [16:0]               total_q, total_d;
    logic [16:0]               remaining_q, remaining_d;
    logic [16:0]               rd_cnt_q, rd_cnt_d;
    logic [C_RAM_AWIDTH-1:0]   raddr_q, raddr_d;
    logic [3:0]                outstanding_q, outstanding_d;
    logic [8:0]                beat_q, beat_d;
    logic [8:0]                blen_q, blen_d;
    logic                      inflight_q, inflight_d;
    logic                      ap_ready_q, ap_ready_d;

    logic [16:0]               to_4k;
    logic [16:0]               burst;
    logic                      start_acc;
    logic                      aw_hs, w_hs, b_hs;
    logic                      last_beat;
    logic                      rd_en;
    logic [1:0]                fifo_count;
    logic [C_M_AXI_DATA_WIDTH-1:0] fifo_dout;

    // Burst size is the smallest of what is left, the burst cap and the room to the next 4 KB page.
    always_comb begin
        to_4k = (17'(BOUNDARY_4K) - {5'd0, addr_q[11:0]}) >> ADDR_LSB;
        burst = remaining_q;
        if (burst > 17'(C_MAX_BURST)) begin
            burst = 17'(C_MAX_BURST);
        end
        if (burst > to_4k) begin
            burst = to_4k;
        end
    end

    assign start_acc      = (state_q == IDLE) && I_ap_start;
    assign O_maxi_awvalid = (state_q == AW) && (outstanding_q != 4'(C_MAX_OUTSTANDING));
    assign O_maxi_wvalid  = (state_q == W) && (fifo_count != 2'd0);
    assign O_maxi_bready  = (state_q != IDLE);
    assign aw_hs          = O_maxi_awvalid && I_maxi_awready;
    assign w_hs           = O_maxi_wvalid && I_maxi_wready;
    assign b_hs           = I_maxi_bvalid && O_maxi_bready;
    assign last_beat      = (beat_q == blen_q - 9'd1);

    // Keep at most two words between FIFO and RAM pipeline, counting the beat being popped now.
    assign rd_en = (state_q != IDLE) && (rd_cnt_q < total_q) &&
                   ((3'(fifo_count) + 3'(inflight_q) - 3'(w_hs)) < 3'd2);

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        total_d       = total_q;
        remaining_d   = remaining_q;
        beat_d        = beat_q;
        blen_d        = blen_q;
        ap_ready_d    = 1'b0;
        inflight_d    = rd_en;
        rd_cnt_d      = rd_cnt_q + {16'd0, rd_en};
        raddr_d       = raddr_q + {{(C_RAM_AWIDTH-1){1'b0}}, rd_en};
        outstanding_d = outstanding_q;
        if (aw_hs && !b_hs) begin
            outstanding_d = outstanding_q + 4'd1;
        end else if (b_hs && !aw_hs && (outstanding_q != 4'd0)) begin
            outstanding_d = outstanding_q - 4'd1;
        end

        case (state_q)
            IDLE: begin
                if (I_ap_start) begin
                    state_d     = AW;
                    addr_d      = I_base_addr;
                    total_d     = {1'b0, I_len} + 17'd1;
                    remaining_d = {1'b0, I_len} + 17'd1;
                    rd_cnt_d    = 17'd0;
                    raddr_d     = '0;
                    ap_ready_d  = 1'b1;
                end
            end
            AW: begin
                if (aw_hs) begin
                    blen_d  = burst[8:0];
                    beat_d  = 9'd0;
                    state_d = W;
                end
            end
            W: begin
                if (w_hs) begin
                    beat_d = beat_q + 9'd1;
                    if (last_beat) begin
                        addr_d      = addr_q + (ADDR_W'(blen_q) << ADDR_LSB);
                        remaining_d = remaining_q - 17'(blen_q);
                        state_d     = (remaining_q == 17'(blen_q)) ? WAIT_B : AW;
                    end
                end
            end
            WAIT_B: begin
                if (outstanding_d == 4'd0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            total_q       <= 17'd0;
            remaining_q   <= 17'd0;
            rd_cnt_q      <= 17'd0;
            raddr_q       <= '0;
            outstanding_q <= 4'd0;
            beat_q        <= 9'd0;
            blen_q        <= 9'd0;
            inflight_q    <= 1'b0;
            ap_ready_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            total_q       <= total_d;
            remaining_q   <= remaining_d;
            rd_cnt_q      <= rd_cnt_d;
            raddr_q       <= raddr_d;
            outstanding_q <= outstanding_d;
            beat_q        <= beat_d;
            blen_q        <= blen_d;
            inflight_q    <= inflight_d;
            ap_ready_q    <= ap_ready_d;
        end
    end

    obuf_wr_skid #(
        .DW (C_M_AXI_DATA_WIDTH)
    ) u_skid (
        .clk   (I_clk),
        .rst_n (I_rst_n),
        .push  (inflight_q),
        .din   (I_buf_rdata),
        .pop   (w_hs),
        .dout  (fifo_dout),
        .count (fifo_count)
    );

    assign O_ap_done       = (state_q == DONE);
    assign O_ap_idle       = (state_q == IDLE);
    assign O_ap_ready      = ap_ready_q;
    assign O_buf_rd        = rd_en;
    assign O_buf_raddr     = raddr_q;
    assign O_maxi_awid     = '0;
    assign O_maxi_awuser   = '0;
    assign O_maxi_awaddr   = addr_q;
    assign O_maxi_awlen    = 8'(burst - 17'd1);
    assign O_maxi_awsize   = AWSIZE_C;
    assign O_maxi_awburst  = BURST_INCR;
    assign O_maxi_awlock   = 1'b0;
    assign O_maxi_awcache  = 4'd0;
    assign O_maxi_awprot   = 3'd0;
    assign O_maxi_awqos    = 4'd0;
    assign O_maxi_awregion = 4'd0;
    assign O_maxi_wdata    = fifo_dout;
    assign O_maxi_wstrb    = '1;
    assign O_maxi_wlast    = last_beat;

`ifdef OBUF_AXI_WR_BRESP_CHK_EN
    logic err_q, err_d;
    logic unused_bid;

    always_comb begin
        err_d = err_q;
        if (start_acc) begin
            err_d = 1'b0;
        end else if (b_hs && (I_maxi_bresp != RESP_OKAY)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign O_bresp_err = err_q;
    assign unused_bid  = ^{I_maxi_bid, start_acc};
`else
    logic unused_b;
    assign unused_b = ^{I_maxi_bid, I_maxi_bresp, start_acc};
`endif

endmodule

// File: tb/tb_obuf_axi_wr.sv
// Directed bench for obuf_axi_wr: RAM model, AXI write slave and per-beat
// data/burst checks against hand-computed burst tables.
module tb_obuf_axi_wr;

    localparam int DW = 128;
    localparam int AWD = 32;
    localparam int RW = 16;

    logic            I_clk;
    logic            I_rst_n;
    logic            I_ap_start;
    logic            O_ap_done, O_ap_idle, O_ap_ready;
    logic [AWD-1:0]  I_base_addr;
    logic [15:0]     I_len;
    logic            O_buf_rd;
    logic [RW-1:0]   O_buf_raddr;
    logic [DW-1:0]   I_buf_rdata;
    logic [0:0]      O_maxi_awid, O_maxi_awuser;
    logic [AWD-1:0]  O_maxi_awaddr;
    logic [7:0]      O_maxi_awlen;
    logic [2:0]      O_maxi_awsize;
    logic [1:0]      O_maxi_awburst;
    logic            O_maxi_awlock;
    logic [3:0]      O_maxi_awcache;
    logic [2:0]      O_maxi_awprot;
    logic [3:0]      O_maxi_awqos, O_maxi_awregion;
    logic            O_maxi_awvalid, I_maxi_awready;
    logic [DW-1:0]   O_maxi_wdata;
    logic [DW/8-1:0] O_maxi_wstrb;
    logic            O_maxi_wlast, O_maxi_wvalid, I_maxi_wready;
    logic [0:0]      I_maxi_bid;
    logic [1:0]      I_maxi_bresp;
    logic            I_maxi_bvalid, O_maxi_bready;
`ifdef OBUF_AXI_WR_BRESP_CHK_EN
    logic            O_bresp_err;
`endif

    obuf_axi_wr #(
        .C_MAX_OUTSTANDING (2)
    ) dut (
        .I_clk           (I_clk),
        .I_rst_n         (I_rst_n),
        .I_ap_start      (I_ap_start),
        .O_ap_done       (O_ap_done),
        .O_ap_idle       (O_ap_idle),
        .O_ap_ready      (O_ap_ready),
        .I_base_addr     (I_base_addr),
        .I_len           (I_len),
        .O_buf_rd        (O_buf_rd),
        .O_buf_raddr     (O_buf_raddr),
        .I_buf_rdata     (I_buf_rdata),
        .O_maxi_awid     (O_maxi_awid),
        .O_maxi_awuser   (O_maxi_awuser),
        .O_maxi_awaddr   (O_maxi_awaddr),
        .O_maxi_awlen    (O_maxi_awlen),
        .O_maxi_awsize   (O_maxi_awsize),
        .O_maxi_awburst  (O_maxi_awburst),
        .O_maxi_awlock   (O_maxi_awlock),
        .O_maxi_awcache  (O_maxi_awcache),
        .O_maxi_awprot   (O_maxi_awprot),
        .O_maxi_awqos    (O_maxi_awqos),
        .O_maxi_awregion (O_maxi_awregion),
        .O_maxi_awvalid  (O_maxi_awvalid),
        .I_maxi_awready  (I_maxi_awready),
        .O_maxi_wdata    (O_maxi_wdata),
        .O_maxi_wstrb    (O_maxi_wstrb),
        .O_maxi_wlast    (O_maxi_wlast),
        .O_maxi_wvalid   (O_maxi_wvalid),
        .I_maxi_wready   (I_maxi_wready),
        .I_maxi_bid      (I_maxi_bid),
        .I_maxi_bresp    (I_maxi_bresp),
        .I_maxi_bvalid   (I_maxi_bvalid),
        .O_maxi_bready   (O_maxi_bready)
`ifdef OBUF_AXI_WR_BRESP_CHK_EN
        ,
        .O_bresp_err     (O_bresp_err)
`endif
    );

    int vec_cnt = 0;
    int err_cnt = 0;

    // Slave/monitor bookkeeping
    int          cyc, aw_cnt, beat_cnt, burst_beat, burst_idx, wl_cnt, b_cnt, pend_b;
    int          done_cnt, done_cyc, last_b_cyc, ready_cnt;
    logic [31:0] aw_addr [8];
    int          aw_len [8];
    int          b_at_aw [8];
    logic [31:0] exp_addr [8];
    int          exp_len [8];
    logic        b_taken, prev_stall, prev_last, aw_prev_stall;
    logic [DW-1:0] prev_data;
    logic [31:0] prev_awaddr;
    logic        w_rand, aw_rand, b_hold;
    logic [1:0]  next_bresp;

    initial I_clk = 1'b0;
    always #5 I_clk = ~I_clk;

    function automatic logic [DW-1:0] pat(input int unsigned i);
        return {i * 32'h9E3779B1, ~i, 32'hD00D0000 ^ i, i};
    endfunction

    always @(posedge I_clk) begin
        if (O_buf_rd) I_buf_rdata <= pat(32'(O_buf_raddr));
    end

    task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic clearMonitor();
        aw_cnt = 0; beat_cnt = 0; burst_beat = 0; burst_idx = 0; wl_cnt = 0;
        b_cnt = 0; pend_b = 0; done_cnt = 0; done_cyc = -1; last_b_cyc = -100;
        ready_cnt = 0; b_taken = 1'b0; prev_stall = 1'b0; aw_prev_stall = 1'b0;
    endtask

    // AXI slave, RAM-order data checker and handshake bookkeeping
    initial begin
        cyc = 0;
        clearMonitor();
        forever begin
            @(negedge I_clk);
            cyc++;
            if (b_taken) begin
                I_maxi_bvalid = 1'b0;
                b_taken = 1'b0;
            end
            I_maxi_awready = aw_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            I_maxi_wready  = w_rand  ? 1'($urandom_range(0, 1)) : 1'b1;
            if (!I_maxi_bvalid && pend_b > 0 && !b_hold) begin
                I_maxi_bvalid = 1'b1;
                I_maxi_bresp  = next_bresp;
                I_maxi_bid    = 1'b0;
                next_bresp    = 2'b00;
            end
            #1;
            if (I_rst_n) begin
                if (O_maxi_awvalid) begin
                    if (aw_prev_stall) checkOutput("awaddr_hold", O_maxi_awaddr, prev_awaddr);
                    if (I_maxi_awready && aw_cnt < 8) begin
                        aw_addr[aw_cnt] = O_maxi_awaddr;
                        aw_len[aw_cnt]  = int'(O_maxi_awlen);
                        b_at_aw[aw_cnt] = b_cnt;
                        aw_cnt++;
                        checkOutput("awsize", O_maxi_awsize, 3'd4);
                        checkOutput("awburst", O_maxi_awburst, 2'b01);
                        checkOutput("aw_tieoff", {O_maxi_awid, O_maxi_awuser, O_maxi_awlock, O_maxi_awcache,
                                    O_maxi_awprot, O_maxi_awqos, O_maxi_awregion}, 0);
                        checkOutput("wstrb", O_maxi_wstrb, 16'hFFFF);
                    end
                    aw_prev_stall = !I_maxi_awready;
                    prev_awaddr   = O_maxi_awaddr;
                end else begin
                    if (aw_prev_stall) checkOutput("awvalid_hold", O_maxi_awvalid, 1'b1);
                    aw_prev_stall = 1'b0;
                end

                if (O_maxi_wvalid) begin
                    if (prev_stall) begin
                        checkOutput("wdata_hold", O_maxi_wdata, prev_data);
                        checkOutput("wlast_hold", O_maxi_wlast, prev_last);
                    end
                    if (I_maxi_wready) begin
                        checkOutput("wdata", O_maxi_wdata, pat(beat_cnt));
                        beat_cnt++;
                        if (burst_idx < aw_cnt) begin
                            checkOutput("wlast", O_maxi_wlast, burst_beat == aw_len[burst_idx]);
                            if (burst_beat == aw_len[burst_idx]) begin
                                burst_idx++;
                                burst_beat = 0;
                                pend_b++;
                                wl_cnt++;
                            end else begin
                                burst_beat++;
                            end
                        end else begin
                            checkOutput("w_before_aw", aw_cnt, burst_idx + 1);
                        end
                    end
                    prev_stall = !I_maxi_wready;
                    prev_data  = O_maxi_wdata;
                    prev_last  = O_maxi_wlast;
                end else begin
                    if (prev_stall) checkOutput("wvalid_hold", O_maxi_wvalid, 1'b1);
                    prev_stall = 1'b0;
                end

                if (I_maxi_bvalid && O_maxi_bready) begin
                    b_cnt++;
                    pend_b--;
                    last_b_cyc = cyc;
                    b_taken = 1'b1;
                end
                if (O_ap_done) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
                if (O_ap_ready) ready_cnt++;
            end
        end
    end

    task automatic applyStimulus(input logic [31:0] base, input logic [15:0] len);
        @(negedge I_clk);
        clearMonitor();
        I_base_addr = base;
        I_len       = len;
        I_ap_start  = 1'b1;
        @(negedge I_clk);
        #2;
        I_ap_start = 1'b0;
        checkOutput("ap_ready", ready_cnt, 1);
        checkOutput("ap_idle_busy", O_ap_idle, 1'b0);
    endtask

    task automatic waitDone(input int budget);
        int n;
        n = 0;
        while (done_cnt == 0 && n < budget) begin
            @(negedge I_clk);
            n++;
        end
        #2;
        if (done_cnt == 0) checkOutput("done_timeout", done_cnt, 1);
        repeat (3) @(negedge I_clk);
        #2;
    endtask

    task automatic checkBursts(input int nb, input int beats);
        checkOutput("aw_count", aw_cnt, nb);
        for (int i = 0; i < nb && i < aw_cnt; i++) begin
            checkOutput($sformatf("awaddr%0d", i), aw_addr[i], exp_addr[i]);
            checkOutput($sformatf("awlen%0d", i), aw_len[i], exp_len[i]);
        end
        checkOutput("beats", beat_cnt, beats);
        checkOutput("b_count", b_cnt, nb);
        checkOutput("done_pulses", done_cnt, 1);
        checkOutput("ready_pulses", ready_cnt, 1);
        checkOutput("done_after_b", done_cyc, last_b_cyc + 1);
        checkOutput("idle_after", O_ap_idle, 1'b1);
    endtask

    task automatic waitCond(input string tag, input int budget, input int which, input int target);
        int n;
        n = 0;
        while (((which == 0) ? wl_cnt : beat_cnt) < target && n < budget) begin
            @(negedge I_clk);
            n++;
        end
        #2;
        if (n >= budget) checkOutput(tag, (which == 0) ? wl_cnt : beat_cnt, target);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        w_rand = 1'b0; aw_rand = 1'b0; b_hold = 1'b0; next_bresp = 2'b00;
        I_ap_start = 1'b0; I_base_addr = '0; I_len = '0;
        I_maxi_bvalid = 1'b0; I_maxi_bresp = 2'b00; I_maxi_bid = 1'b0;
        I_maxi_awready = 1'b0; I_maxi_wready = 1'b0;
        I_rst_n = 1'b0;
        repeat (3) @(negedge I_clk);
        #2;
        checkOutput("rst_awvalid", O_maxi_awvalid, 1'b0);
        checkOutput("rst_wvalid", O_maxi_wvalid, 1'b0);
        checkOutput("rst_bready", O_maxi_bready, 1'b0);
        checkOutput("rst_done", O_ap_done, 1'b0);
        checkOutput("rst_ready", O_ap_ready, 1'b0);
        checkOutput("rst_buf_rd", O_buf_rd, 1'b0);
        checkOutput("rst_idle", O_ap_idle, 1'b1);
        @(negedge I_clk);
        I_rst_n = 1'b1;

        // Stray B response while idle must not be accepted
        @(negedge I_clk);
        #2;
        I_maxi_bvalid = 1'b1;
        I_maxi_bresp  = 2'b10;
        @(negedge I_clk);
        #2;
        checkOutput("idle_bready", O_maxi_bready, 1'b0);
        I_maxi_bvalid = 1'b0;
        I_maxi_bresp  = 2'b00;

        $display("[TB] single burst at 0x1000");
        applyStimulus(32'h1000, 16'd15);
        waitDone(500);
        exp_addr[0] = 32'h1000; exp_len[0] = 15;
        checkBursts(1, 16);
`ifdef OBUF_AXI_WR_BRESP_CHK_EN
        checkOutput("bresp_err_okay", O_bresp_err, 1'b0);
`endif

        $display("[TB] 600 beats split at 4 KB pages");
        applyStimulus(32'h0, 16'd599);
        waitDone(3000);
        exp_addr[0] = 32'h0;    exp_len[0] = 255;
        exp_addr[1] = 32'h1000; exp_len[1] = 255;
        exp_addr[2] = 32'h2000; exp_len[2] = 87;
        checkBursts(3, 600);

        $display("[TB] start just below 4 KB boundary");
        applyStimulus(32'hF80, 16'd15);
        waitDone(500);
        exp_addr[0] = 32'hF80;  exp_len[0] = 7;
        exp_addr[1] = 32'h1000; exp_len[1] = 7;
        checkBursts(2, 16);

        $display("[TB] single beat");
        applyStimulus(32'h40, 16'd0);
        waitDone(200);
        exp_addr[0] = 32'h40; exp_len[0] = 0;
        checkBursts(1, 1);

        $display("[TB] random ready back-pressure");
        w_rand = 1'b1; aw_rand = 1'b1;
        applyStimulus(32'h0, 16'd63);
        waitDone(2000);
        w_rand = 1'b0; aw_rand = 1'b0;
        exp_addr[0] = 32'h0; exp_len[0] = 63;
        checkBursts(1, 64);

        $display("[TB] outstanding limit with withheld B");
        b_hold = 1'b1;
        next_bresp = 2'b10;
        applyStimulus(32'h0, 16'd767);
        waitCond("two_bursts_timeout", 2000, 0, 2);
        repeat (20) @(negedge I_clk);
        #2;
        checkOutput("aw_held_count", aw_cnt, 2);
        checkOutput("aw_held_valid", O_maxi_awvalid, 1'b0);
        checkOutput("aw_held_busy", O_ap_idle, 1'b0);
        b_hold = 1'b0;
        waitDone(2000);
        exp_addr[0] = 32'h0;    exp_len[0] = 255;
        exp_addr[1] = 32'h1000; exp_len[1] = 255;
        exp_addr[2] = 32'h2000; exp_len[2] = 255;
        checkBursts(3, 768);
        checkOutput("aw3_after_b", b_at_aw[2] >= 1, 1'b1);
`ifdef OBUF_AXI_WR_BRESP_CHK_EN
        checkOutput("bresp_err_set", O_bresp_err, 1'b1);
`endif

        $display("[TB] reset in the middle of a transfer");
        applyStimulus(32'h0, 16'd599);
`ifdef OBUF_AXI_WR_BRESP_CHK_EN
        checkOutput("bresp_err_clr", O_bresp_err, 1'b0);
`endif
        waitCond("mid_w_timeout", 500, 1, 40);
        @(posedge I_clk);
        #3;
        I_rst_n = 1'b0;
        #1;
        checkOutput("arst_awvalid", O_maxi_awvalid, 1'b0);
        checkOutput("arst_wvalid", O_maxi_wvalid, 1'b0);
        checkOutput("arst_bready", O_maxi_bready, 1'b0);
        checkOutput("arst_buf_rd", O_buf_rd, 1'b0);
        checkOutput("arst_idle", O_ap_idle, 1'b1);
        I_maxi_bvalid = 1'b0;
        pend_b = 0; b_taken = 1'b0; prev_stall = 1'b0; aw_prev_stall = 1'b0;
        repeat (3) @(negedge I_clk);
        I_rst_n = 1'b1;
        repeat (3) @(negedge I_clk);
        #2;
        checkOutput("no_done_after_abort", done_cnt, 0);

        applyStimulus(32'h3000, 16'd31);
        waitDone(500);
        exp_addr[0] = 32'h3000; exp_len[0] = 31;
        checkBursts(1, 32);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
